timers_sfr_if: RTL and testbench

//  SFR front-end for top_timers. Decodes CPU SFR reads/writes to TCON, TMOD and
//  the 24-bit Timer0/Timer1 count bytes (THx/TMx/TLx).

---
 rtl/timers_sfr_if.sv | 205 ++++++++++++++++++++
 tb/tb_timers_sfr_if.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timers_sfr_if.sv
// SFR front-end for the timer block: holds TCON/TMOD and the 24-bit count images,
// arbitrates the overflow flags and serves CPU reads with a coherent count snapshot.
module timers_sfr_if #(
    parameter logic [7:0] ADDR_TCON = 8'h88,
    parameter logic [7:0] ADDR_TMOD = 8'h89,
    parameter logic [7:0] ADDR_TL0  = 8'h8A,
    parameter logic [7:0] ADDR_TL1  = 8'h8B,
    parameter logic [7:0] ADDR_TH0  = 8'h8C,
    parameter logic [7:0] ADDR_TH1  = 8'h8D,
    parameter logic [7:0] ADDR_TM0  = 8'hA2,
    parameter logic [7:0] ADDR_TM1  = 8'hA3
) (
    input  logic       timers_sfr_if_machine_cycle_i,
    input  logic       timers_sfr_if_reset_i,
    input  logic [7:0] timers_sfr_if_addr_i,
    input  logic [7:0] timers_sfr_if_wdata_i,
    input  logic       timers_sfr_if_wr_i,
    input  logic       timers_sfr_if_rd_i,
    output logic [7:0] timers_sfr_if_rdata_o,
    output logic       timers_sfr_if_rvalid_o,
    input  logic       timers_sfr_if_ack_t0_i,
    input  logic       timers_sfr_if_ack_t1_i,
    input  logic       timers_sfr_if_tf_hw_t0_i,
    input  logic       timers_sfr_if_tf_hw_t1_i,
    input  logic [7:0] timers_sfr_if_th_cnt_0_i,
    input  logic [7:0] timers_sfr_if_tm_cnt_0_i,
    input  logic [7:0] timers_sfr_if_tl_cnt_0_i,
    input  logic [7:0] timers_sfr_if_th_cnt_1_i,
    input  logic [7:0] timers_sfr_if_tm_cnt_1_i,
    input  logic [7:0] timers_sfr_if_tl_cnt_1_i,
    output logic       timers_sfr_if_tmod_gate_t0_o,
    output logic       timers_sfr_if_tmod_m0_t0_o,
    output logic       timers_sfr_if_tmod_m1_t0_o,
    output logic       timers_sfr_if_tmod_gate_t1_o,
    output logic       timers_sfr_if_tmod_m0_t1_o,
    output logic       timers_sfr_if_tmod_m1_t1_o,
    output logic       timers_sfr_if_tcon_tr0_o,
    output logic       timers_sfr_if_tcon_tr1_o,
    output logic       timers_sfr_if_tcon_tf0_o,
    output logic       timers_sfr_if_tcon_tf1_o,
    output logic [7:0] timers_sfr_if_th_0_o,
    output logic [7:0] timers_sfr_if_tm_0_o,
    output logic [7:0] timers_sfr_if_tl_0_o,
    output logic [7:0] timers_sfr_if_th_1_o,
    output logic [7:0] timers_sfr_if_tm_1_o,
    output logic [7:0] timers_sfr_if_tl_1_o
);

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] wdata;

    assign clk   = timers_sfr_if_machine_cycle_i;
    assign rst   = timers_sfr_if_reset_i;
    assign addr  = timers_sfr_if_addr_i;
    assign wdata = timers_sfr_if_wdata_i;

    logic [7:0] tcon_q, tcon_d;
    logic [7:0] tmod_q;
    logic [7:0] rdata_q, rd_mux;
    logic       rvalid_q;

    logic [7:0] th_0_q, tm_0_q, tl_0_q;
    logic [7:0] th_1_q, tm_1_q, tl_1_q;

    logic       snap_0_q, snap_1_q;
    logic [7:0] sh_tm_0_q, sh_th_0_q;
    logic [7:0] sh_tm_1_q, sh_th_1_q;

    logic wr_tcon, wr_tmod;
    logic wr_tl0, wr_tm0, wr_th0, wr_tl1, wr_tm1, wr_th1;
    logic rd_tl0, rd_th0, rd_tl1, rd_th1;

    assign wr_tcon = timers_sfr_if_wr_i && (addr == ADDR_TCON);
    assign wr_tmod = timers_sfr_if_wr_i && (addr == ADDR_TMOD);
    assign wr_tl0  = timers_sfr_if_wr_i && (addr == ADDR_TL0);
    assign wr_tm0  = timers_sfr_if_wr_i && (addr == ADDR_TM0);
    assign wr_th0  = timers_sfr_if_wr_i && (addr == ADDR_TH0);
    assign wr_tl1  = timers_sfr_if_wr_i && (addr == ADDR_TL1);
    assign wr_tm1  = timers_sfr_if_wr_i && (addr == ADDR_TM1);
    assign wr_th1  = timers_sfr_if_wr_i && (addr == ADDR_TH1);

    assign rd_tl0 = timers_sfr_if_rd_i && (addr == ADDR_TL0);
    assign rd_th0 = timers_sfr_if_rd_i && (addr == ADDR_TH0);
    assign rd_tl1 = timers_sfr_if_rd_i && (addr == ADDR_TL1);
    assign rd_th1 = timers_sfr_if_rd_i && (addr == ADDR_TH1);

    // TF bits: hardware set beats interrupt ack, which beats a TCON write.
    always_comb begin
        tcon_d = wr_tcon ? wdata : tcon_q;
        if (timers_sfr_if_ack_t0_i)   tcon_d[5] = 1'b0;
        if (timers_sfr_if_tf_hw_t0_i) tcon_d[5] = 1'b1;
        if (timers_sfr_if_ack_t1_i)   tcon_d[7] = 1'b0;
        if (timers_sfr_if_tf_hw_t1_i) tcon_d[7] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcon_q <= 8'h00;
            tmod_q <= 8'h00;
        end else begin
            tcon_q <= tcon_d;
            if (wr_tmod) tmod_q <= wdata;
        end
    end

    // Count images follow the live counter unless the CPU overwrites that byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            th_0_q <= 8'h00;
            tm_0_q <= 8'h00;
            tl_0_q <= 8'h00;
            th_1_q <= 8'h00;
            tm_1_q <= 8'h00;
            tl_1_q <= 8'h00;
        end else begin
            th_0_q <= wr_th0 ? wdata : timers_sfr_if_th_cnt_0_i;
            tm_0_q <= wr_tm0 ? wdata : timers_sfr_if_tm_cnt_0_i;
            tl_0_q <= wr_tl0 ? wdata : timers_sfr_if_tl_cnt_0_i;
            th_1_q <= wr_th1 ? wdata : timers_sfr_if_th_cnt_1_i;
            tm_1_q <= wr_tm1 ? wdata : timers_sfr_if_tm_cnt_1_i;
            tl_1_q <= wr_tl1 ? wdata : timers_sfr_if_tl_cnt_1_i;
        end
    end

    // Snapshot: a TL read freezes TM/TH, a TH read releases them.
    // A write to any count byte of the timer also releases, overriding a same-cycle TL read.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_0_q  <= 1'b0;
            snap_1_q  <= 1'b0;
            sh_tm_0_q <= 8'h00;
            sh_th_0_q <= 8'h00;
            sh_tm_1_q <= 8'h00;
            sh_th_1_q <= 8'h00;
        end else begin
            if (rd_tl0) begin
                sh_tm_0_q <= timers_sfr_if_tm_cnt_0_i;
                sh_th_0_q <= timers_sfr_if_th_cnt_0_i;
            end
            if (rd_tl1) begin
                sh_tm_1_q <= timers_sfr_if_tm_cnt_1_i;
                sh_th_1_q <= timers_sfr_if_th_cnt_1_i;
            end
            if (wr_tl0 || wr_tm0 || wr_th0) snap_0_q <= 1'b0;
            else if (rd_tl0)                snap_0_q <= 1'b1;
            else if (rd_th0)                snap_0_q <= 1'b0;
            if (wr_tl1 || wr_tm1 || wr_th1) snap_1_q <= 1'b0;
            else if (rd_tl1)                snap_1_q <= 1'b1;
            else if (rd_th1)                snap_1_q <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            ADDR_TCON: rd_mux = tcon_q;
            ADDR_TMOD: rd_mux = tmod_q;
            ADDR_TL0:  rd_mux = timers_sfr_if_tl_cnt_0_i;
            ADDR_TM0:  rd_mux = snap_0_q ? sh_tm_0_q : timers_sfr_if_tm_cnt_0_i;
            ADDR_TH0:  rd_mux = snap_0_q ? sh_th_0_q : timers_sfr_if_th_cnt_0_i;
            ADDR_TL1:  rd_mux = timers_sfr_if_tl_cnt_1_i;
            ADDR_TM1:  rd_mux = snap_1_q ? sh_tm_1_q : timers_sfr_if_tm_cnt_1_i;
            ADDR_TH1:  rd_mux = snap_1_q ? sh_th_1_q : timers_sfr_if_th_cnt_1_i;
            default:   rd_mux = 8'h00;
        endcase
    end

    // Read handshake: rd_i is a one-cycle strobe with no back-pressure; each rd_i
    // not coincident with reset yields exactly one rvalid_o pulse the next cycle,
    // carrying the register value from before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= timers_sfr_if_rd_i;
            rdata_q  <= timers_sfr_if_rd_i ? rd_mux : 8'h00;
        end
    end

    assign timers_sfr_if_rdata_o  = rdata_q;
    assign timers_sfr_if_rvalid_o = rvalid_q;

    assign timers_sfr_if_tmod_gate_t1_o = tmod_q[7];
    assign timers_sfr_if_tmod_m1_t1_o   = tmod_q[5];
    assign timers_sfr_if_tmod_m0_t1_o   = tmod_q[4];
    assign timers_sfr_if_tmod_gate_t0_o = tmod_q[3];
    assign timers_sfr_if_tmod_m1_t0_o   = tmod_q[1];
    assign timers_sfr_if_tmod_m0_t0_o   = tmod_q[0];

    assign timers_sfr_if_tcon_tf1_o = tcon_q[7];
    assign timers_sfr_if_tcon_tr1_o = tcon_q[6];
    assign timers_sfr_if_tcon_tf0_o = tcon_q[5];
    assign timers_sfr_if_tcon_tr0_o = tcon_q[4];

    assign timers_sfr_if_th_0_o = th_0_q;
    assign timers_sfr_if_tm_0_o = tm_0_q;
    assign timers_sfr_if_tl_0_o = tl_0_q;
    assign timers_sfr_if_th_1_o = th_1_q;
    assign timers_sfr_if_tm_1_o = tm_1_q;
    assign timers_sfr_if_tl_1_o = tl_1_q;

endmodule

// File: tb/tb_timers_sfr_if.sv
// Randomised bench for timers_sfr_if: a byte-level register model predicts reads
// (queued) and per-cycle outputs; a negedge monitor compares against the DUT.
module tb_timers_sfr_if;

    localparam logic [7:0] A_TCON = 8'h88, A_TMOD = 8'h89;
    localparam logic [7:0] A_TL0 = 8'h8A, A_TL1 = 8'h8B, A_TH0 = 8'h8C, A_TH1 = 8'h8D;
    localparam logic [7:0] A_TM0 = 8'hA2, A_TM1 = 8'hA3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] addr = 8'h00, wdata = 8'h00;
    logic       wr = 1'b0, rd = 1'b0;
    logic       ack0 = 1'b0, ack1 = 1'b0, hw0 = 1'b0, hw1 = 1'b0;
    logic [7:0] tl_c [2];
    logic [7:0] tm_c [2];
    logic [7:0] th_c [2];

    logic [7:0] rdata;
    logic       rvalid;
    logic       g0, m00, m10, g1, m01, m11, tr0, tr1, tf0, tf1;
    logic [7:0] th0, tm0, tl0, th1, tm1, tl1;

    timers_sfr_if dut (
        .timers_sfr_if_machine_cycle_i (clk),
        .timers_sfr_if_reset_i         (rst),
        .timers_sfr_if_addr_i          (addr),
        .timers_sfr_if_wdata_i         (wdata),
        .timers_sfr_if_wr_i            (wr),
        .timers_sfr_if_rd_i            (rd),
        .timers_sfr_if_rdata_o         (rdata),
        .timers_sfr_if_rvalid_o        (rvalid),
        .timers_sfr_if_ack_t0_i        (ack0),
        .timers_sfr_if_ack_t1_i        (ack1),
        .timers_sfr_if_tf_hw_t0_i      (hw0),
        .timers_sfr_if_tf_hw_t1_i      (hw1),
        .timers_sfr_if_th_cnt_0_i      (th_c[0]),
        .timers_sfr_if_tm_cnt_0_i      (tm_c[0]),
        .timers_sfr_if_tl_cnt_0_i      (tl_c[0]),
        .timers_sfr_if_th_cnt_1_i      (th_c[1]),
        .timers_sfr_if_tm_cnt_1_i      (tm_c[1]),
        .timers_sfr_if_tl_cnt_1_i      (tl_c[1]),
        .timers_sfr_if_tmod_gate_t0_o  (g0),
        .timers_sfr_if_tmod_m0_t0_o    (m00),
        .timers_sfr_if_tmod_m1_t0_o    (m10),
        .timers_sfr_if_tmod_gate_t1_o  (g1),
        .timers_sfr_if_tmod_m0_t1_o    (m01),
        .timers_sfr_if_tmod_m1_t1_o    (m11),
        .timers_sfr_if_tcon_tr0_o      (tr0),
        .timers_sfr_if_tcon_tr1_o      (tr1),
        .timers_sfr_if_tcon_tf0_o      (tf0),
        .timers_sfr_if_tcon_tf1_o      (tf1),
        .timers_sfr_if_th_0_o          (th0),
        .timers_sfr_if_tm_0_o          (tm0),
        .timers_sfr_if_tl_0_o          (tl0),
        .timers_sfr_if_th_1_o          (th1),
        .timers_sfr_if_tm_1_o          (tm1),
        .timers_sfr_if_tl_1_o          (tl1)
    );

    // reference model: register bytes, count images by slot (timer*3 + {tl,tm,th}), snapshots
    logic [7:0] m_tcon, m_tmod;
    logic [7:0] m_img [6];
    logic       m_snap [2];
    logic [7:0] m_sh [2][3];
    logic       m_rvalid;
    logic [7:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    function automatic int slot_of(logic [7:0] a);
        case (a)
            A_TL0: return 0;  A_TM0: return 1;  A_TH0: return 2;
            A_TL1: return 3;  A_TM1: return 4;  A_TH1: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] live(int s);
        case (s % 3)
            0:       return tl_c[s / 3];
            1:       return tm_c[s / 3];
            default: return th_c[s / 3];
        endcase
    endfunction

    function automatic logic [7:0] read_value(logic [7:0] a);
        int s;
        s = slot_of(a);
        if (a == A_TCON) return m_tcon;
        if (a == A_TMOD) return m_tmod;
        if (s < 0) return 8'h00;
        if (s % 3 == 0) return live(s);
        return m_snap[s / 3] ? m_sh[s / 3][s % 3] : live(s);
    endfunction

    task automatic model_step();
        int s;
        if (rst) begin
            m_tcon = 8'h00;
            m_tmod = 8'h00;
            for (int i = 0; i < 6; i++) m_img[i] = 8'h00;
            for (int t = 0; t < 2; t++) m_snap[t] = 1'b0;
            m_rvalid = 1'b0;
            return;
        end
        s = slot_of(addr);
        m_rvalid = rd;
        if (rd) exp_q.push_back(read_value(addr));
        if (rd && s >= 0 && s % 3 == 0) begin
            m_snap[s / 3] = 1'b1;
            m_sh[s / 3][1] = tm_c[s / 3];
            m_sh[s / 3][2] = th_c[s / 3];
        end
        if (rd && s >= 0 && s % 3 == 2) m_snap[s / 3] = 1'b0;
        if (wr && s >= 0) m_snap[s / 3] = 1'b0;
        if (wr && addr == A_TCON) m_tcon = wdata;
        if (ack0) m_tcon[5] = 1'b0;
        if (hw0)  m_tcon[5] = 1'b1;
        if (ack1) m_tcon[7] = 1'b0;
        if (hw1)  m_tcon[7] = 1'b1;
        if (wr && addr == A_TMOD) m_tmod = wdata;
        for (int i = 0; i < 6; i++) m_img[i] = (wr && s == i) ? wdata : live(i);
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rvalid", {7'd0, rvalid}, {7'd0, m_rvalid});
            if (rvalid === 1'b1) begin
                if (exp_q.size() == 0) chk("rdata_unexpected", rdata, 8'hxx);
                else chk("rdata", rdata, exp_q.pop_front());
            end
            chk("tf0", {7'd0, tf0}, {7'd0, m_tcon[5]});
            chk("tr0", {7'd0, tr0}, {7'd0, m_tcon[4]});
            chk("tf1", {7'd0, tf1}, {7'd0, m_tcon[7]});
            chk("tr1", {7'd0, tr1}, {7'd0, m_tcon[6]});
            chk("tmod_fields", {2'b00, g1, m11, m01, g0, m10, m00},
                {2'b00, m_tmod[7], m_tmod[5], m_tmod[4], m_tmod[3], m_tmod[1], m_tmod[0]});
            chk("tl_0_o", tl0, m_img[0]);
            chk("tm_0_o", tm0, m_img[1]);
            chk("th_0_o", th0, m_img[2]);
            chk("tl_1_o", tl1, m_img[3]);
            chk("tm_1_o", tm1, m_img[4]);
            chk("th_1_o", th1, m_img[5]);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_wr(logic [7:0] a, logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1; rd = 1'b0;
        step();
        wr = 1'b0;
    endtask

    task automatic do_rd(logic [7:0] a);
        addr = a; rd = 1'b1; wr = 1'b0;
        step();
        rd = 1'b0;
    endtask

    task automatic set_cnt(int t, logic [7:0] l, logic [7:0] m, logic [7:0] h);
        tl_c[t] = l; tm_c[t] = m; th_c[t] = h;
    endtask

    logic [7:0] addr_tab [12];

    initial begin
        addr_tab = '{A_TCON, A_TMOD, A_TL0, A_TL1, A_TH0, A_TH1, A_TM0, A_TM1,
                     8'h00, 8'hFF, 8'h90, 8'hA4};
        set_cnt(0, 8'h00, 8'h00, 8'h00);
        set_cnt(1, 8'h00, 8'h00, 8'h00);

        // 1: reset, then read every address
        rst = 1'b1;
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 12; i++) do_rd(addr_tab[i]);
        step();

        // 2: TMOD write and readback
        do_wr(A_TMOD, 8'hA5);
        do_rd(A_TMOD);
        step();

        // 3: coherent snapshot of timer 0
        set_cnt(0, 8'h12, 8'h34, 8'h56);
        do_rd(A_TL0);
        set_cnt(0, 8'hFF, 8'hFF, 8'hFF);
        do_rd(A_TM0);
        do_rd(A_TH0);
        do_rd(A_TH0);
        step();

        // 4: hardware set beats software clear and ack
        hw0 = 1'b1; ack0 = 1'b1;
        do_wr(A_TCON, 8'h00);
        hw0 = 1'b0;
        step();
        ack0 = 1'b0;
        step();

        // 5: TL1 write overrides the live count for one cycle
        set_cnt(1, 8'h10, 8'h20, 8'h30);
        do_wr(A_TL1, 8'h80);
        step();
        step();

        // same-address read and write together return the old value
        do_wr(A_TCON, 8'h5A);
        addr = A_TCON; wdata = 8'hC3; wr = 1'b1; rd = 1'b1;
        step();
        wr = 1'b0; rd = 1'b0;
        step();

        // 6: reset arriving with a read strobe drops the read
        hw1 = 1'b1;
        do_wr(A_TMOD, 8'hFF);
        hw1 = 1'b0;
        addr = A_TCON; rd = 1'b1; rst = 1'b1;
        step();
        rd = 1'b0; rst = 1'b0;
        step();

        // randomised traffic
        for (int n = 0; n < 2000; n++) begin
            addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                : addr_tab[$urandom_range(0, 11)];
            wdata = 8'($urandom_range(0, 255));
            wr    = ($urandom_range(0, 2) == 0);
            rd    = ($urandom_range(0, 1) == 0);
            hw0   = ($urandom_range(0, 7) == 0);
            hw1   = ($urandom_range(0, 7) == 0);
            ack0  = ($urandom_range(0, 7) == 0);
            ack1  = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0)
                set_cnt(int'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            step();
        end
        wr = 1'b0; rd = 1'b0; rst = 1'b0;
        hw0 = 1'b0; hw1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
        step();
        step();
        @(negedge clk);
        #1;
        chk("exp_q_drained", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
